// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, one-outstanding imem handshake, prefetch FIFO, IF/ID register.
// Optional FETCH_PERF_EN adds perf_fetched / perf_bubbles saturating counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 Reset,
`ifdef FETCH_PERF_EN
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_bubbles,
`endif
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    output logic                 IF_ID_valid,
    output logic [31:0]          IF_ID_instr,
    output logic [31:0]          IF_ID_pc
);
    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t        r_state, w_nxt_state;
    logic [31:0]   r_pc, r_tgt, w_pc_nxt, w_tgt_nxt, w_btgt;
    logic          r_req, w_req_nxt, w_ack, w_push, w_pop;
    logic [AW:0]   r_count, w_count_nxt;
    logic [AW-1:0] r_wptr, r_rptr;
    entry_t        r_mem [DEPTH];
    logic          w_unused;

    assign w_btgt         = {branch_target[31:2], 2'b00};
    assign w_unused       = ^branch_target[1:0];
    assign w_ack          = r_req & imem.imem_ack;
    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_nxt_state;
    end

    // A redirect with an un-acked request outstanding must drain that request first.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE:  w_nxt_state = S_FETCH;
            S_FETCH: if (branch_taken && r_req && !imem.imem_ack) w_nxt_state = S_FLUSH;
            S_FLUSH: if (imem.imem_ack) w_nxt_state = S_FETCH;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_push      = (r_state == S_FETCH) && w_ack && !branch_taken;
        w_pop       = !stall && !branch_taken && (r_count != '0);
        w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        if (branch_taken) w_count_nxt = '0;
        w_pc_nxt  = r_pc;
        w_tgt_nxt = r_tgt;
        w_req_nxt = r_req;
        case (r_state)
            S_IDLE: begin
                w_req_nxt = 1'b1;
                if (branch_taken) w_pc_nxt = w_btgt;
            end
            S_FETCH: begin
                if (branch_taken) begin
                    if (r_req && !imem.imem_ack) w_tgt_nxt = w_btgt;
                    else begin
                        w_pc_nxt  = w_btgt;
                        w_req_nxt = 1'b1;
                    end
                end else if (w_ack || !r_req) begin
                    // Issue guard: count after this edge plus the new request must fit.
                    if (w_ack) w_pc_nxt = r_pc + 32'd4;
                    w_req_nxt = (w_count_nxt < CNT_DEPTH);
                end
            end
            S_FLUSH: begin
                if (branch_taken) w_tgt_nxt = w_btgt;
                if (imem.imem_ack) begin
                    w_pc_nxt  = branch_taken ? w_btgt : r_tgt;
                    w_req_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_pc        <= RESET_PC;
            r_tgt       <= RESET_PC;
            r_req       <= 1'b0;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            IF_ID_valid <= 1'b0;
            IF_ID_instr <= 32'h0;
            IF_ID_pc    <= 32'h0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
            r_req   <= w_req_nxt;
            r_count <= w_count_nxt;
            if (branch_taken) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
            end
            if (branch_taken) IF_ID_valid <= 1'b0;
            else if (!stall) begin
                IF_ID_valid <= w_pop;
                if (w_pop) begin
                    IF_ID_pc    <= r_mem[r_rptr].pc;
                    IF_ID_instr <= r_mem[r_rptr].instr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= '{pc: r_pc, instr: imem.imem_rdata};
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            perf_fetched <= 32'h0;
            perf_bubbles <= 32'h0;
        end else begin
            if (w_push && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
            if (!stall && !w_pop && perf_bubbles != 32'hFFFF_FFFF) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif
endmodule
